// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state encoding and address helpers for the LCD bus responder
package lcd_pkg;

    localparam int BUSY_CYCLES = 40;
    localparam int DDRAM_DEPTH = 80;
    localparam int LINE_LEN    = 40;

    localparam logic [6:0] LINE0_LAST  = 7'h27;
    localparam logic [6:0] LINE1_FIRST = 7'h40;
    localparam logic [6:0] LINE1_LAST  = 7'h67;

    localparam logic [7:0] FILL_CHAR = 8'h20;

    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
    localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
    localparam logic [7:0] CMD_SHIFT     = 8'h10;
    localparam logic [7:0] CMD_DISPLAY   = 8'h08;
    localparam logic [7:0] CMD_ENTRY     = 8'h04;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= LINE0_LAST) || ((a >= LINE1_FIRST) && (a <= LINE1_LAST));
    endfunction

    // The two display lines are not contiguous, so stepping hops the gap in both directions.
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
        if (up) begin
            if (a == LINE0_LAST)      r = LINE1_FIRST;
            else if (a == LINE1_LAST) r = 7'h00;
            else                      r = a + 7'd1;
        end else begin
            if (a == 7'h00)            r = LINE1_LAST;
            else if (a == LINE1_FIRST) r = LINE0_LAST;
            else                       r = a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [6:0] addr_to_idx(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + 7'(LINE_LEN)) : {1'b0, a[5:0]};
    endfunction

    function automatic logic [6:0] idx_to_addr(input logic [6:0] i);
        return (i < 7'(LINE_LEN)) ? i : (i + (LINE1_FIRST - 7'(LINE_LEN)));
    endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// rtl/lcd_bus_responder_if.sv - HD44780-style parallel bus between initiator and responder
interface lcd_bus_responder_if;

    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    modport master (
        output lcd_data,
        output lcd_rs,
        output lcd_rw,
        output lcd_en
    );

    modport slave (
        input lcd_data,
        input lcd_rs,
        input lcd_rw,
        input lcd_en
    );

endinterface

// File: rtl/lcd_ddram.sv
// rtl/lcd_ddram.sv - 80x8 display data RAM, one write port and one synchronous read port
module lcd_ddram (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata
);
    import lcd_pkg::*;

    logic [7:0] mem [0:DDRAM_DEPTH-1];
    logic [6:0] widx;
    logic [6:0] ridx;

    assign widx = addr_to_idx(waddr);
    assign ridx = addr_to_idx(raddr);

    // Array contents are never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we && addr_valid(waddr)) begin
            mem[widx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 8'h00;
        end else begin
            rdata <= addr_valid(raddr) ? mem[ridx] : 8'h00;
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - HD44780-style bus responder: strobe capture, command decode, DDRAM update
module lcd_bus_responder (
    input  logic               clk,
    input  logic               rst,
    lcd_bus_responder_if.slave bus,
    input  logic [6:0]         rd_addr,
    output logic [7:0]         rd_data,
    output logic [6:0]         cur_addr,
    output logic               display_on,
    output logic               cursor_on,
    output logic               blink_on,
    output logic               entry_inc,
    output logic               func_8bit,
    output logic               func_2line,
    output logic               init_done,
    output logic               busy,
    output logic               cmd_valid,
    output logic [7:0]         cmd_byte,
    output logic               cmd_rs,
    output logic               overrun,
    output logic               proto_err
);
    import lcd_pkg::*;

    logic [10:0] sync_meta;
    logic [10:0] sync_q;
    logic        en_prev;
    logic        en_fall;
    logic        rs_s;
    logic        rw_s;
    logic [7:0]  data_s;

    // Bus order inside the synchronizer: {en, rs, rw, data}.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
            en_prev   <= 1'b0;
        end else begin
            sync_meta <= {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data};
            sync_q    <= sync_meta;
            en_prev   <= sync_q[10];
        end
    end

    assign rs_s    = sync_q[9];
    assign rw_s    = sync_q[8];
    assign data_s  = sync_q[7:0];
    assign en_fall = en_prev & ~sync_q[10];

    state_t     state;
    state_t     state_next;
    logic [6:0] cnt;
    logic [6:0] cnt_next;
    logic       accept;
    logic       cap_rs;
    logic [7:0] cap_data;
    logic       mem_we;
    logic [6:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       clear_last;

    assign clear_last = (state == ST_CLEAR) && (cnt == 7'(DDRAM_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 7'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = cur_addr;
        mem_wdata  = cap_data;
        case (state)
            ST_IDLE: begin
                if (en_fall && !rw_s) begin
                    accept     = 1'b1;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                cnt_next = 7'd0;
                mem_we   = cap_rs;
                if (!cap_rs && (cap_data == CMD_CLEAR)) begin
                    state_next = ST_CLEAR;
                end else begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt == 7'(BUSY_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + 7'd1;
                end
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = idx_to_addr(cnt);
                mem_wdata = FILL_CHAR;
                if (clear_last) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + 7'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_rs     <= 1'b0;
            cap_data   <= 8'h00;
            cur_addr   <= 7'h00;
            display_on <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            entry_inc  <= 1'b1;
            func_8bit  <= 1'b1;
            func_2line <= 1'b0;
            init_done  <= 1'b0;
            overrun    <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            if (accept) begin
                cap_rs   <= rs_s;
                cap_data <= data_s;
            end
            if (en_fall && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            if (en_fall && (state == ST_IDLE) && rw_s) begin
                proto_err <= 1'b1;
            end
            if (state == ST_EXEC) begin
                if (cap_rs) begin
                    cur_addr <= addr_step(cur_addr, entry_inc);
                end else if ((cap_data & CMD_SET_DDRAM) != 8'h00) begin
                    if (addr_valid(cap_data[6:0])) begin
                        cur_addr <= cap_data[6:0];
                    end else begin
                        cur_addr  <= 7'h00;
                        proto_err <= 1'b1;
                    end
                end else if ((cap_data & CMD_SET_CGRAM) != 8'h00) begin
                    // CGRAM is not modelled; the address is accepted and discarded.
                end else if ((cap_data & CMD_FUNC_SET) != 8'h00) begin
                    func_8bit  <= cap_data[4];
                    func_2line <= cap_data[3];
                    init_done  <= 1'b1;
                end else if ((cap_data & CMD_SHIFT) != 8'h00) begin
                    if (!cap_data[3]) begin
                        cur_addr <= addr_step(cur_addr, cap_data[2]);
                    end
                end else if ((cap_data & CMD_DISPLAY) != 8'h00) begin
                    display_on <= cap_data[2];
                    cursor_on  <= cap_data[1];
                    blink_on   <= cap_data[0];
                end else if ((cap_data & CMD_ENTRY) != 8'h00) begin
                    entry_inc <= cap_data[1];
                end else if ((cap_data & CMD_HOME) != 8'h00) begin
                    cur_addr <= 7'h00;
                end
            end
            if (clear_last) begin
                cur_addr  <= 7'h00;
                entry_inc <= 1'b1;
            end
        end
    end

    assign busy      = (state != ST_IDLE);
    assign cmd_valid = (state == ST_EXEC);
    assign cmd_byte  = cap_data;
    assign cmd_rs    = cap_rs;

    lcd_ddram u_ddram (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we & ~rst),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
